// File: rtl/fwd_stream_arbiter.sv
// fwd_stream_arbiter: packet-atomic round-robin merge of NUM_FILTERS
// forwarder AXI Streams onto one registered egress AXI Stream.
//
// Ports:
//   axi_aclk, axi_aresetn : clock (rising edge), async active-low reset
//   in_TDATA/TVALID/TLAST : packed per-input streams, input i at
//                           [i*DATA_WIDTH +: DATA_WIDTH]
//   in_TREADY             : per-input ready (only the grantee, in BUSY)
//   out_TDATA/TVALID/TLAST: registered egress beat
//   out_TREADY            : egress ready
//   out_TDEST             : source index of the egress beat; present
//                           only when FWD_ARB_TDEST_EN is defined
//
// The grant is held from arbitration until the grantee's TLAST beat is
// accepted, so packets never interleave. One IDLE cycle separates
// consecutive packets; that cycle is where the round-robin scan runs.
module fwd_stream_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_FILTERS = 4,
    parameter int SEL_WIDTH   = 2
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic [NUM_FILTERS*DATA_WIDTH-1:0] in_TDATA,
    input  logic [NUM_FILTERS-1:0]            in_TVALID,
    input  logic [NUM_FILTERS-1:0]            in_TLAST,
    output logic [NUM_FILTERS-1:0]            in_TREADY,
    output logic [DATA_WIDTH-1:0]             out_TDATA,
    output logic                              out_TVALID,
    output logic                              out_TLAST,
    input  logic                              out_TREADY
`ifdef FWD_ARB_TDEST_EN
    ,
    output logic [SEL_WIDTH-1:0]              out_TDEST
`endif
);

    if (NUM_FILTERS < 2 || NUM_FILTERS > 8) begin : g_bad_num
        $error("NUM_FILTERS must be in 2..8");
    end
    if (SEL_WIDTH != $clog2(NUM_FILTERS)) begin : g_bad_sel
        $error("SEL_WIDTH must equal clog2(NUM_FILTERS)");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                 state;
    logic [SEL_WIDTH-1:0]   grant;
    logic [SEL_WIDTH-1:0]   last_grant;
    logic [SEL_WIDTH-1:0]   winner;
    logic                   any_valid;
    logic                   slot_free;
    logic                   accept;
    logic                   grant_last;
    logic [DATA_WIDTH-1:0]  grant_data;
    logic [DATA_WIDTH-1:0]  beat [NUM_FILTERS];

    for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_split
        assign beat[i] = in_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin scan starting just after last_grant. The loop runs
    // from the farthest offset down to the nearest so the nearest valid
    // input is the one left in winner.
    always_comb begin : rr_scan
        logic [SEL_WIDTH-1:0] idx;
        idx       = '0;
        winner    = last_grant;
        any_valid = 1'b0;
        for (int k = NUM_FILTERS; k >= 1; k--) begin
            idx = SEL_WIDTH'((int'(last_grant) + k) % NUM_FILTERS);
            if (in_TVALID[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    // Output register can take a new beat when empty or draining now.
    assign slot_free  = !out_TVALID || out_TREADY;
    assign grant_data = beat[grant];
    assign grant_last = in_TLAST[grant];
    assign accept     = (state == BUSY) && in_TVALID[grant] && slot_free;

    always_comb begin
        in_TREADY = '0;
        if (state == BUSY) begin
            in_TREADY[grant] = slot_free;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= SEL_WIDTH'(NUM_FILTERS - 1);
            out_TDATA  <= '0;
            out_TVALID <= 1'b0;
            out_TLAST  <= 1'b0;
`ifdef FWD_ARB_TDEST_EN
            out_TDEST  <= '0;
`endif
        end else begin
            // The egress register drains in any state, so the final
            // beat of a packet still leaves during the IDLE cycle.
            if (accept) begin
                out_TDATA  <= grant_data;
                out_TLAST  <= grant_last;
                out_TVALID <= 1'b1;
`ifdef FWD_ARB_TDEST_EN
                out_TDEST  <= grant;
`endif
            end else if (out_TVALID && out_TREADY) begin
                out_TVALID <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant <= winner;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && grant_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fwd_stream_arbiter.sv
// tb_fwd_stream_arbiter: scoreboard bench for fwd_stream_arbiter.
// Directed scenarios followed by randomized traffic with valid gaps.
`timescale 1ns/1ps
module tb_fwd_stream_arbiter;

    localparam int DW = 64;
    localparam int NF = 4;
    localparam int SW = 2;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NF*DW-1:0] in_TDATA = '0;
    logic [NF-1:0]    in_TVALID = '0;
    logic [NF-1:0]    in_TLAST = '0;
    logic [NF-1:0]    in_TREADY;
    logic [DW-1:0]    out_TDATA;
    logic             out_TVALID;
    logic             out_TLAST;
    logic             out_TREADY = 1'b1;
`ifdef FWD_ARB_TDEST_EN
    logic [SW-1:0]    out_TDEST;
`endif

    fwd_stream_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_FILTERS(NF),
        .SEL_WIDTH  (SW)
    ) dut (
        .axi_aclk   (clk),
        .axi_aresetn(rst_n),
        .in_TDATA   (in_TDATA),
        .in_TVALID  (in_TVALID),
        .in_TLAST   (in_TLAST),
        .in_TREADY  (in_TREADY),
        .out_TDATA  (out_TDATA),
        .out_TVALID (out_TVALID),
        .out_TLAST  (out_TLAST),
        .out_TREADY (out_TREADY)
`ifdef FWD_ARB_TDEST_EN
        ,
        .out_TDEST  (out_TDEST)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    beat_t src_q[NF][$];
    beat_t exp_q[NF][$];
    int    gq[$];
    int    started[$];
    bit    rdy_pat[$];
    bit    gap_en = 0;
    bit    rnd_rdy = 0;
    bit    hold_en = 0;
    bit    hold_val = 1;
    bit    gapchk_en = 0;
    int    seq = 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NF-1:0] v);
        for (int k = 1; k <= NF; k++) begin
            if (v[(last + k) % NF]) return (last + k) % NF;
        end
        return -1;
    endfunction

    function automatic int pending();
        int n;
        n = gq.size();
        for (int i = 0; i < NF; i++) n += src_q[i].size() + exp_q[i].size();
        return n;
    endfunction

    task automatic push_pkt(input int src, input int len,
                            input logic [31:0] low0);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.d = {8'(src), 24'(seq), low0 + 32'(j)};
            b.l = (j == len - 1);
            src_q[src].push_back(b);
            exp_q[src].push_back(b);
        end
        seq++;
    endtask

    // Source driver: retire beats that transferred, present queue heads.
    initial begin : driver
        logic [NF-1:0] fired;
        forever begin
            @(negedge clk);
            fired = in_TVALID & in_TREADY;
            @(posedge clk);
            #1;
            for (int i = 0; i < NF; i++) begin
                if (fired[i] && src_q[i].size() > 0)
                    void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    in_TVALID[i] = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                    in_TDATA[i*DW +: DW] = src_q[i][0].d;
                    in_TLAST[i] = src_q[i][0].l;
                end else begin
                    in_TVALID[i] = 1'b0;
                    in_TLAST[i] = 1'b0;
                    in_TDATA[i*DW +: DW] = {$urandom, $urandom};
                end
            end
            if (rdy_pat.size() > 0) out_TREADY = rdy_pat.pop_front();
            else if (hold_en) out_TREADY = hold_val;
            else if (rnd_rdy) out_TREADY = ($urandom_range(0, 9) < 7);
            else out_TREADY = 1'b1;
        end
    end

    // Monitor: transaction-level model of grant order and ready rules.
    bit             m_idle = 1;
    int             m_last = NF - 1;
    int             m_grant = 0;
    bit             in_pkt = 0;
    bit             prev_stall = 0;
    bit             have_prev = 0;
    int             cur = 0;
    int             idle_cnt = 0;
    logic [DW-1:0]  prev_d;
    logic           prev_l;

    always @(negedge clk) begin : monitor
        logic [NF-1:0] exp_rdy;
        int src;
        int w;
        beat_t e;
        if (!rst_n) begin
            for (int i = 0; i < NF; i++) exp_q[i].delete();
            gq.delete();
            m_idle = 1;
            m_last = NF - 1;
            m_grant = 0;
            in_pkt = 0;
            prev_stall = 0;
            have_prev = 0;
            idle_cnt = 0;
        end else begin
            exp_rdy = '0;
            if (!m_idle) exp_rdy[m_grant] = !out_TVALID || out_TREADY;
            chk("in_tready", 64'(in_TREADY), 64'(exp_rdy));
            if (prev_stall) begin
                chk("stall_valid", 64'(out_TVALID), 64'(1));
                chk("stall_data", out_TDATA, prev_d);
                chk("stall_last", 64'(out_TLAST), 64'(prev_l));
            end
            prev_stall = out_TVALID && !out_TREADY;
            prev_d = out_TDATA;
            prev_l = out_TLAST;
            if (!out_TVALID) idle_cnt++;
            if (out_TVALID && out_TREADY) begin
                src = int'(out_TDATA[DW-1:DW-8]);
                if (!in_pkt) begin
                    started.push_back(src);
                    if (gq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL grant_order: got src %0d expected none", src);
                    end else begin
                        chk("grant_order", 64'(src), 64'(gq.pop_front()));
                    end
                    if (gapchk_en && have_prev)
                        chk("pkt_gap", 64'(idle_cnt), 64'(1));
                end else begin
                    chk("interleave", 64'(src), 64'(cur));
                end
                cur = src;
                if (src < NF && exp_q[src].size() > 0) begin
                    e = exp_q[src].pop_front();
                    chk("beat_data", out_TDATA, e.d);
                    chk("beat_last", 64'(out_TLAST), 64'(e.l));
                end else begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat_data: got %h expected nothing", out_TDATA);
                end
`ifdef FWD_ARB_TDEST_EN
                chk("tdest", 64'(out_TDEST), 64'(src));
`endif
                in_pkt = !out_TLAST;
                if (out_TLAST) begin
                    have_prev = 1;
                    idle_cnt = 0;
                end
            end
            if (m_idle) begin
                if (|in_TVALID) begin
                    w = rr_pick(m_last, in_TVALID);
                    m_grant = w;
                    m_idle = 0;
                    gq.push_back(w);
                end
            end else if (in_TVALID[m_grant] && in_TREADY[m_grant]
                         && in_TLAST[m_grant]) begin
                m_idle = 1;
                m_last = m_grant;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NF; i++) src_q[i].delete();
        in_TVALID = '0;
        in_TLAST = '0;
        hold_en = 0;
        rdy_pat.delete();
        repeat (2) @(negedge clk);
        chk("rst_out_tvalid", 64'(out_TVALID), 64'(0));
        chk("rst_out_tlast", 64'(out_TLAST), 64'(0));
        chk("rst_out_tdata", out_TDATA, 64'(0));
        chk("rst_in_tready", 64'(in_TREADY), 64'(0));
`ifdef FWD_ARB_TDEST_EN
        chk("rst_out_tdest", 64'(out_TDEST), 64'(0));
`endif
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((pending() != 0 || out_TVALID) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(n < budget), 64'(1));
    endtask

    task automatic wait_out(input string nm);
        int n;
        n = 0;
        while (!out_TVALID && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(n < 50), 64'(1));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int t0;
        int s5;
        beat_t b;
        int exp2[6];
        int exp4[3];
        exp2 = '{0, 1, 2, 0, 1, 2};
        exp4 = '{3, 0, 1};

        do_reset();

        // Three beats from input 0, first-beat latency.
        push_pkt(0, 3, 32'hA0);
        n = 0;
        while (!in_TVALID[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        wait_out("t1_wait_out");
        chk("t1_latency", 64'(cyc - t0), 64'(2));
        chk("t1_first_data", 64'(out_TDATA[7:0]), 64'h0A0);
        drain("t1_drain", 200);

        // Three inputs with two 2-beat packets each, all valid at once.
        do_reset();
        gapchk_en = 1;
        started.delete();
        @(negedge clk);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 3; i++)
                push_pkt(i, 2, 32'h100 * (r + 1));
        drain("t2_drain", 300);
        gapchk_en = 0;
        chk("t2_pkt_count", 64'(started.size()), 64'(6));
        for (int k = 0; k < 6 && k < started.size(); k++)
            chk("t2_order", 64'(started[k]), 64'(exp2[k]));

        // Backpressure pattern on a 4-beat packet from input 1.
        push_pkt(1, 4, 32'hB0);
        wait_out("t3_wait_out");
        rdy_pat = '{1, 0, 0, 1, 1, 0, 1};
        drain("t3_drain", 200);

        // Input 3 mid-packet when inputs 0 and 1 raise valid.
        started.delete();
        push_pkt(3, 4, 32'hC0);
        wait_out("t4_wait_out");
        push_pkt(0, 2, 32'hD0);
        push_pkt(1, 2, 32'hE0);
        n = 0;
        while (!in_TREADY[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_ready0_seen", 64'(n < 100), 64'(1));
        chk("t4_in3_done", 64'(src_q[3].size()), 64'(0));
        drain("t4_drain", 300);
        chk("t4_pkt_count", 64'(started.size()), 64'(3));
        for (int k = 0; k < 3 && k < started.size(); k++)
            chk("t4_order", 64'(started[k]), 64'(exp4[k]));

        // Reset while beat 2 of 5 from input 2 sits in the output register.
        s5 = seq;
        push_pkt(2, 5, 32'h5000_0000);
        n = 0;
        while (!(out_TVALID && out_TREADY) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_first_fire", 64'(n < 50), 64'(1));
        hold_en = 1;
        hold_val = 0;
        @(negedge clk);
        chk("t5_held_valid", 64'(out_TVALID), 64'(1));
        chk("t5_held_data", out_TDATA, {8'd2, 24'(s5), 32'h5000_0001});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_tvalid", 64'(out_TVALID), 64'(0));
        chk("t5_async_tdata", out_TDATA, 64'(0));
        chk("t5_async_tready", 64'(in_TREADY), 64'(0));
        @(negedge clk);
        #1;
        for (int i = 0; i < NF; i++) src_q[i].delete();
        in_TVALID = '0;
        in_TLAST = '0;
        hold_en = 0;
        rst_n = 1'b1;
        started.delete();
        push_pkt(3, 1, 32'hF3);
        push_pkt(2, 1, 32'hF2);
        push_pkt(0, 1, 32'hF0);
        drain("t5_drain", 200);
        chk("t5_first_after_rst", 64'(started.size() > 0 ? started[0] : -1), 64'(0));

        // Single-beat packet 0x55 from input 2.
        b.d = 64'h0200_0000_0000_0055;
        b.l = 1'b1;
        src_q[2].push_back(b);
        exp_q[2].push_back(b);
        wait_out("t6_wait_out");
        chk("t6_last", 64'(out_TLAST), 64'(1));
        chk("t6_data", 64'(out_TDATA[7:0]), 64'h55);
`ifdef FWD_ARB_TDEST_EN
        chk("t6_tdest", 64'(out_TDEST), 64'(2));
`endif
        drain("t6_drain", 100);

        // Randomized traffic with valid gaps and random egress ready.
        gap_en = 1;
        rnd_rdy = 1;
        for (int bt = 0; bt < 40; bt++) begin
            n = $urandom_range(1, 3);
            for (int p = 0; p < n; p++)
                push_pkt($urandom_range(0, NF - 1), $urandom_range(1, 5), $urandom);
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        drain("rand_drain", 5000);
        gap_en = 0;
        rnd_rdy = 0;

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
